// File: rtl/decode_pkg.sv
// Shared definitions for the decoder frame path: bank indices, a constant
// ceil-log2 helper and the legal-range test for the frame length.
package decode_pkg;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // A frame must hold at least two symbols and fit inside one bank.
    function automatic bit frame_len_ok(input int len, input int asize);
        return (len >= 2) && (len <= (1 << (asize - 1)));
    endfunction

endpackage

// File: rtl/frame_bank_ctrl.sv
// Ping-pong bank bookkeeping shared by the writer and the read stage.
// A bank is "full" from its last write until the consumer releases it, and
// "ready" (published) one cycle after its last write so that the write has
// committed to the RAM before any read can be issued.
module frame_bank_ctrl
    import decode_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       close_i,
    input  logic       close_bank_i,
    input  logic       done_i,
    output logic [1:0] bank_full_o,
    output logic [1:0] bank_full_nxt_o,
    output logic       frm_valid_o,
    output logic       frm_bank_o
);

    logic [1:0] full_q, full_d;
    logic [1:0] rdy_q, rdy_d;
    logic       rd_bank_q, rd_bank_d;
    logic       pend_q, pend_d;
    logic       pend_bank_q, pend_bank_d;
    logic       rel;

    // A release is honoured only while the presented bank is published.
    assign rel = done_i && rdy_q[rd_bank_q];

    // Next state: close, delayed publish and release touch disjoint banks,
    // because a bank being closed or pending is never published yet.
    always_comb begin
        full_d      = full_q;
        rdy_d       = rdy_q;
        rd_bank_d   = rd_bank_q;
        pend_d      = close_i;
        pend_bank_d = pend_bank_q;

        if (close_i) begin
            full_d[close_bank_i] = 1'b1;
            pend_bank_d          = close_bank_i;
        end

        if (pend_q) begin
            rdy_d[pend_bank_q] = 1'b1;
        end

        if (rel) begin
            full_d[rd_bank_q] = 1'b0;
            rdy_d[rd_bank_q]  = 1'b0;
            rd_bank_d         = (rd_bank_q == BANK0) ? BANK1 : BANK0;
        end
    end

    // Bank flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            rdy_q       <= 2'b00;
            rd_bank_q   <= BANK0;
            pend_q      <= 1'b0;
            pend_bank_q <= BANK0;
        end else begin
            full_q      <= full_d;
            rdy_q       <= rdy_d;
            rd_bank_q   <= rd_bank_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
        end
    end

    assign bank_full_o     = full_q;
    assign bank_full_nxt_o = full_d;
    assign frm_valid_o     = rdy_q[rd_bank_q];
    assign frm_bank_o      = rd_bank_q;

endmodule

// File: rtl/frame_loader.sv
// Frame writer: turns a valid/ready symbol stream into fixed-length frames
// written into alternating halves (banks) of the frame RAM. Frame boundaries
// come from the beat count alone; s_last is only cross-checked and any
// disagreement is flagged on err_len.
module frame_loader
    import decode_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 10,
    parameter int FRAME_LEN = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [ASIZE-1:0] addrc,
    output logic [DSIZE-1:0] dinc,
    output logic             wec,
    output logic             frm_valid,
    output logic             frm_bank,
    input  logic             frm_done,
    output logic             err_len
);

    localparam int CW = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);
    localparam int AW = ASIZE - 1;

    generate
        if (!frame_len_ok(FRAME_LEN, ASIZE)) begin : g_bad_frame_len
            $error("frame_loader: FRAME_LEN must be in 2 .. 2**(ASIZE-1)");
        end
    endgenerate

    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             s_ready_q, s_ready_d;
    logic             wec_q, wec_d;
    logic [ASIZE-1:0] addrc_q, addrc_d;
    logic [DSIZE-1:0] dinc_q, dinc_d;
    logic             err_q, err_d;

    logic             acc;
    logic             at_end;
    logic             close;
    logic [AW-1:0]    cnt_ext;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;

    assign acc     = s_valid && s_ready_q;
    assign at_end  = (wr_cnt_q == CW'(FRAME_LEN - 1));
    assign close   = acc && at_end;
    assign cnt_ext = AW'(wr_cnt_q);

    frame_bank_ctrl u_bank_ctrl (
        .clk             (clk),
        .rst_n           (rst_n),
        .close_i         (close),
        .close_bank_i    (wr_bank_q),
        .done_i          (frm_done),
        .bank_full_o     (bank_full),
        .bank_full_nxt_o (bank_full_nxt),
        .frm_valid_o     (frm_valid),
        .frm_bank_o      (frm_bank)
    );

    // Writer next state: count position, bank flip, RAM port and length check.
    // s_ready looks at the next bank's next fullness so a release seen this
    // cycle reopens a stalled writer on the following cycle.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        wec_d     = acc;
        addrc_d   = addrc_q;
        dinc_d    = dinc_q;
        err_d     = 1'b0;

        if (acc) begin
            addrc_d = {wr_bank_q, cnt_ext};
            dinc_d  = s_data;
            err_d   = (s_last != at_end);
            if (at_end) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end

        s_ready_d = !bank_full_nxt[wr_bank_d];
    end

    // Writer registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= BANK0;
            s_ready_q <= 1'b0;
            wec_q     <= 1'b0;
            addrc_q   <= '0;
            dinc_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            s_ready_q <= s_ready_d;
            wec_q     <= wec_d;
            addrc_q   <= addrc_d;
            dinc_q    <= dinc_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wec     = wec_q;
    assign addrc   = addrc_q;
    assign dinc    = dinc_q;
    assign err_len = err_q;

    // The partial-state view of the full flags is not needed by the writer
    // beyond s_ready; keep it observable for the read stage hookup.
    logic unused_full;
    assign unused_full = ^bank_full;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader with DSIZE=8, ASIZE=4, FRAME_LEN=8.
module tb_frame_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [3:0] addrc;
    logic [7:0] dinc;
    logic       wec;
    logic       frm_valid;
    logic       frm_bank;
    logic       frm_done;
    logic       err_len;

    int checks;
    int failures;

    frame_loader #(
        .DSIZE     (8),
        .ASIZE     (4),
        .FRAME_LEN (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .addrc     (addrc),
        .dinc      (dinc),
        .wec       (wec),
        .frm_valid (frm_valid),
        .frm_bank  (frm_bank),
        .frm_done  (frm_done),
        .err_len   (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last,
                             input logic [3:0] ea, input logic ee);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        step();
        chk("wec", wec, 1);
        chk("addrc", addrc, ea);
        chk("dinc", dinc, d);
        chk("err_len", err_len, ee);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        frm_done = 1'b0;
        s_data   = 8'h00;
        #1;
        chk("rst_wec", wec, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_frm_valid", frm_valid, 0);
        chk("rst_addrc", addrc, 0);
        chk("rst_frm_bank", frm_bank, 0);
        chk("rst_err_len", err_len, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", s_ready, 0);
        chk("post_rst_wec", wec, 0);
        step();
        chk("first_edge_s_ready", s_ready, 1);
        chk("first_edge_frm_valid", frm_valid, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_data   = 8'h00;
        frm_done = 1'b0;
        #12;

        // 1. Single frame into bank 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h10 + 8'(i), (i == 7), 4'(i), 1'b0);
        end
        chk("s1_frm_valid_early", frm_valid, 0);
        step();
        chk("s1_frm_valid", frm_valid, 1);
        chk("s1_frm_bank", frm_bank, 0);
        chk("s1_err_len", err_len, 0);
        chk("s1_wec_idle", wec, 0);

        // 2. Backpressure with both banks full.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            send_beat(8'(i), (i % 8 == 0), 4'(i - 1), 1'b0);
        end
        chk("s2_s_ready_stall", s_ready, 0);
        s_data  = 8'd17;
        s_valid = 1'b1;
        step();
        chk("s2_no_write_1", wec, 0);
        chk("s2_frm_valid", frm_valid, 1);
        chk("s2_frm_bank0", frm_bank, 0);
        step();
        chk("s2_no_write_2", wec, 0);
        chk("s2_still_stalled", s_ready, 0);
        frm_done = 1'b1;
        step();
        frm_done = 1'b0;
        chk("s2_rel_frm_bank", frm_bank, 1);
        chk("s2_rel_frm_valid", frm_valid, 1);
        chk("s2_rel_s_ready", s_ready, 1);
        chk("s2_rel_no_write", wec, 0);
        for (int i = 17; i <= 24; i++) begin
            send_beat(8'(i), (i == 24), 4'(i - 17), 1'b0);
        end
        chk("s2_restall", s_ready, 0);

        // 3. Early s_last on beat 5.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h30 + 8'(i), (i == 4) || (i == 7), 4'(i), (i == 4));
        end
        step();
        chk("s3_err_after", err_len, 0);
        chk("s3_frm_valid", frm_valid, 1);

        // 4. Missing s_last on beat 8.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h40 + 8'(i), 1'b0, 4'(i), (i == 7));
        end
        step();
        chk("s4_err_after", err_len, 0);
        chk("s4_frm_valid", frm_valid, 1);
        chk("s4_frm_bank", frm_bank, 0);

        // 5. Close of bank 1 and release of bank 0 in the same cycle.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send_beat(8'h50 + 8'(i), (i == 7), 4'(i), 1'b0);
        end
        chk("s5_bank0_published", frm_valid, 1);
        frm_done = 1'b1;
        send_beat(8'h5f, 1'b1, 4'd15, 1'b0);
        frm_done = 1'b0;
        chk("s5_same_cycle_bank", frm_bank, 1);
        chk("s5_same_cycle_valid", frm_valid, 0);
        chk("s5_same_cycle_ready", s_ready, 1);
        send_beat(8'h60, 1'b0, 4'd0, 1'b0);
        chk("s5_bank1_published", frm_valid, 1);
        chk("s5_bank1_index", frm_bank, 1);
        frm_done = 1'b1;
        step();
        chk("s5_rel1_valid", frm_valid, 0);
        chk("s5_rel1_bank", frm_bank, 0);
        step();
        frm_done = 1'b0;
        chk("s5_ignored_valid", frm_valid, 0);
        chk("s5_ignored_bank", frm_bank, 0);
        chk("s5_ignored_ready", s_ready, 1);
        send_beat(8'h61, 1'b0, 4'd1, 1'b0);

        // 6. Reset in the middle of a frame.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send_beat(8'h70 + 8'(i), (i == 7), 4'(i), 1'b0);
        end
        chk("s6_pre_frm_valid", frm_valid, 1);
        chk("s6_pre_s_ready", s_ready, 1);
        do_reset();
        send_beat(8'h99, 1'b0, 4'd0, 1'b0);
        chk("s6_bank_after", frm_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
# frame_loader

Upstream write stage for the decoder's 3-port frame RAM (1 write port, 2 read ports). It accepts a valid/ready symbol stream and writes fixed-length frames into the RAM write port (`addrc`/`dinc`/`wec`). The RAM is split into two ping-pong banks. Each completed bank is handed to the downstream read stage, which releases it with `frm_done`. The RAM itself is instantiated in the parent, not inside this block.

## Interface
- `DSIZE`, 8, symbol width; equals the RAM data width.
- `ASIZE`, 10, RAM address width. The MSB selects the bank.
- `FRAME_LEN`, 256, symbols per frame. Legal range is 2 ≤ `FRAME_LEN` ≤ 2**(ASIZE-1).
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DSIZE  input symbol.
- `s_valid`  in  1  symbol valid.
- `s_last`  in  1  upstream end-of-frame marker; used for checking only.
- `s_ready`  out  1  block can accept a symbol.
- `addrc`  out  ASIZE  RAM write address.
- `dinc`  out  DSIZE  RAM write data.
- `wec`  out  1  RAM write enable.
- `frm_valid`  out  1  a completed bank is available to the consumer.
- `frm_bank`  out  1  bank index presented to the consumer.
- `frm_done`  in  1  single-cycle pulse from the consumer releasing `frm_bank`.
- `err_len`  out  1  one-cycle pulse when `s_last` does not match the frame position.

## Operation
- **Accept rule.** A beat is accepted on a rising edge where `s_valid` and `s_ready` are both high.
- **Writer state:**
  - `wr_bank` (1 bit)
  - `wr_cnt` (0..FRAME_LEN-1)
  - `bank_full[1:0]`: bank is written, or is closing.
  - `bank_rdy[1:0]`: bank is published to the consumer.
  - `rd_bank` (1 bit)
- **Write port.** For each accepted beat, `addrc = {wr_bank, wr_cnt}` (`wr_cnt` zero-extended to ASIZE-1 bits) and `dinc = s_data`, with `wec` asserted. `wec`, `addrc` and `dinc` are registered.
- **Mid-frame beat.** An accepted beat with `wr_cnt < FRAME_LEN-1` increments `wr_cnt`.
- **Last beat of a frame.** An accepted beat with `wr_cnt == FRAME_LEN-1`:
  - sets `bank_full[wr_bank]`;
  - clears `wr_cnt`;
  - toggles `wr_bank`;
  - sets `bank_rdy` for the closed bank one cycle later, after its last write has committed.
- **Frame boundary.** Frames are closed by count only. `s_last` never changes addressing.
- **Length error.** `err_len` pulses if either:
  - `s_last` = 1 on a beat with `wr_cnt != FRAME_LEN-1`, or
  - `s_last` = 0 on the beat with `wr_cnt == FRAME_LEN-1`.
- **`s_ready`.** Registered, loaded each edge with `!bank_full[next wr_bank]`. The next-state source guarantees no beat is accepted into an occupied bank.
- **Consumer side.**
  - `frm_valid = bank_rdy[rd_bank]` and `frm_bank = rd_bank`.
  - `frm_done` while `frm_valid` = 1 clears `bank_full[rd_bank]` and `bank_rdy[rd_bank]`, and toggles `rd_bank`.
  - `frm_done` while `frm_valid` = 0 is ignored.
- **Simultaneous events.** A last-beat close of one bank and `frm_done` on the other bank in the same cycle are both applied.
- **Release of a stalled bank.** If the writer is stalled on the bank being released, `s_ready` rises in the cycle after `frm_done`.

## Timing
- **Reset values.** During reset and in the first cycle after `rst_n` rises, all outputs are 0, `wr_bank` = `rd_bank` = 0 and all flags are clear. `s_ready` goes to 1 at the first edge after release.
- **Write latency.** A beat accepted at edge E drives `wec`/`addrc`/`dinc` during cycle E..E+1, and the RAM commits it at edge E+1.
- **Publish latency.** For a last beat accepted at edge E, `frm_valid` rises after edge E+1. The consumer's first read therefore samples at edge E+2 or later and never sees stale data (RAM is read-first).
- **Throughput.** 1 symbol per clock. The writer stalls only when both banks are full.
- **Release latency.** After `frm_done` sampled at edge D, `frm_valid` reflects the other bank after D.
- **Reset mid-operation.** The partial frame is discarded. `wec` drops immediately (asynchronously), and the next frame starts at address 0 of bank 0.

## Structure
- **Shared `decode_pkg`:**
  - bank-index constants `BANK0`/`BANK1`;
  - a `clog2` function for the `wr_cnt` width;
  - an elaboration-time check on the `FRAME_LEN` range.
- **Submodules.** None required; the block is one module of about 150–250 lines. The bank bookkeeping (`bank_full`/`bank_rdy`/`rd_bank`) may be split out as `frame_bank_ctrl` if reused by the downstream stage.

## Test plan
All scenarios use `DSIZE`=8, `ASIZE`=4, `FRAME_LEN`=8.
1. **Single frame.** After reset, send beats 0x10..0x17 back-to-back with `s_last` on the 8th.
   - `wec` pulses with `addrc` 0..7 and `dinc` 0x10..0x17, each one cycle after acceptance.
   - `frm_valid` rises 2 cycles after the 8th acceptance with `frm_bank`=0.
   - `err_len` stays 0.
2. **Backpressure.** Send 24 beats with no `frm_done`.
   - Bank 0 is written at addresses 0..7 and bank 1 at addresses 8..15.
   - `s_ready` is 0 from the cycle after the 16th acceptance.
   - Pulse `frm_done`: `frm_bank` becomes 1, `s_ready` rises the next cycle, and beats 17..24 are written to addresses 0..7.
3. **Early `s_last`.** Assert `s_last` on beat 5.
   - One `err_len` pulse follows beat 5.
   - The frame still closes after beat 8, with `frm_valid` asserted.
4. **Missing `s_last`.** Leave `s_last` low on beat 8: one `err_len` pulse; the frame is published normally.
5. **Simultaneous events and ignored release.**
   - `frm_done` for bank 0 arrives in the same cycle bank 1's last beat is accepted: bank 0 is freed and bank 1 is published; no beat is lost.
   - `frm_done` with `frm_valid`=0 changes no state.
6. **Reset mid-frame.** Assert `rst_n`=0 after 3 beats.
   - `wec`, `s_ready` and `frm_valid` go to 0 immediately.
   - After release, the next beat is written to address 0.
